// File: rtl/servo_pkg.sv
// Shared constants for the multi-channel servo PWM block: register map,
// STATUS bit positions and the reset PERIOD.
package servo_pkg;
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_PERIOD = 4'h1;
  localparam logic [3:0] ADDR_STATUS = 4'h2;
  localparam logic [3:0] ADDR_PULSE0 = 4'h8;

  localparam int CTRL_GEN_BIT   = 31;
  localparam int STAT_WRAP_BIT  = 16;
  localparam int DEFAULT_PERIOD = 20000;

  // Reset PERIOD clipped to what a w-bit counter can hold.
  function automatic int unsigned sat_period(input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    if (w < 32 && lim < longint'(DEFAULT_PERIOD)) return 32'(lim);
    return 32'(DEFAULT_PERIOD);
  endfunction
endpackage

// File: rtl/servo_pwm_channel.sv
// One PWM channel: double-buffered pulse width, comparator against the shared
// counter, registered output and a sticky feedback fault flag.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_pulse_we,
  input  logic [CNT_W-1:0] i_wdata,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_out_en,
  input  logic             i_fault_en,
  input  logic             i_response,
  input  logic             i_fault_clr,
  output logic             o_pwm,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_pulse_shadow
);
  logic [CNT_W-1:0] r_pulse_shadow;
  logic [CNT_W-1:0] r_pulse_active;
  logic             r_pwm;
  logic             r_fault;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pulse_shadow <= '0;
      r_pulse_active <= '0;
      r_pwm          <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      if (i_pulse_we) r_pulse_shadow <= i_wdata;
      if (i_load)     r_pulse_active <= r_pulse_shadow;
      r_pwm <= i_out_en & (i_count < r_pulse_active);
      // A fault arriving on the same edge as a clear survives it.
      r_fault <= (r_fault & ~i_fault_clr) | (i_fault_en & r_pwm & ~i_response);
    end
  end

  assign o_pwm          = r_pwm;
  assign o_fault        = r_fault;
  assign o_pulse_shadow = r_pulse_shadow;
endmodule

// File: rtl/servo_pwm_multi.sv
// Avalon-MM multi-channel servo PWM generator: shared period counter,
// double-buffered PERIOD/PULSE registers, sticky W1C STATUS.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [3:0]        address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [NUM_CH-1:0] pwm_response,
  output logic [NUM_CH-1:0] pwm_out
);
  localparam logic [CNT_W-1:0] P_DEF = CNT_W'(sat_period(CNT_W));

  logic              r_gen;
  logic [NUM_CH-1:0] r_ch_en;
  logic [CNT_W-1:0]  r_period_shadow;
  logic [CNT_W-1:0]  r_period_active;
  logic [CNT_W-1:0]  r_count;
  logic              r_wrap_flag;
  logic [31:0]       r_readdata;

  logic              w_wr;
  logic              w_rd;
  logic              w_run;
  logic              w_wrap;
  logic              w_load;
  logic [31:0]       w_stat_clr;
  logic [31:0]       w_rdata;
  logic [NUM_CH-1:0] w_pwm;
  logic [NUM_CH-1:0] w_fault;
  logic [NUM_CH-1:0] w_pulse_we;
  logic [CNT_W-1:0]  w_pulse_shadow [NUM_CH];

  assign w_wr       = chipselect & write;
  assign w_rd       = chipselect & read;
  assign w_run      = r_gen & (r_period_active != '0);
  assign w_wrap     = w_run & (r_count == r_period_active - 1'b1);
  // A zero active period also reloads, so a new PERIOD can escape it.
  assign w_load     = w_wrap | ~r_gen | (r_period_active == '0);
  assign w_stat_clr = (w_wr && address == ADDR_STATUS) ? writedata : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gen           <= 1'b0;
      r_ch_en         <= '0;
      r_period_shadow <= P_DEF;
      r_period_active <= P_DEF;
      r_count         <= '0;
      r_wrap_flag     <= 1'b0;
      r_readdata      <= '0;
    end else begin
      if (w_wr && address == ADDR_CTRL) begin
        r_gen   <= writedata[CTRL_GEN_BIT];
        r_ch_en <= writedata[NUM_CH-1:0];
      end
      if (w_wr && address == ADDR_PERIOD) r_period_shadow <= writedata[CNT_W-1:0];
      if (w_load) r_period_active <= r_period_shadow;
      if (!w_run || w_wrap) r_count <= '0;
      else                  r_count <= r_count + 1'b1;
      r_wrap_flag <= (r_wrap_flag & ~w_stat_clr[STAT_WRAP_BIT]) | w_wrap;
      if (w_rd) r_readdata <= w_rdata;
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    case (address)
      ADDR_CTRL: begin
        w_rdata[NUM_CH-1:0]   = r_ch_en;
        w_rdata[CTRL_GEN_BIT] = r_gen;
      end
      ADDR_PERIOD: w_rdata = 32'(r_period_shadow);
      ADDR_STATUS: begin
        w_rdata[NUM_CH-1:0]    = w_fault;
        w_rdata[STAT_WRAP_BIT] = r_wrap_flag;
      end
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (address == 4'(ADDR_PULSE0 + i)) w_rdata = 32'(w_pulse_shadow[i]);
      end
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_pulse_we[g] = w_wr & (address == 4'(ADDR_PULSE0 + g));

    servo_pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_load         (w_load),
      .i_pulse_we     (w_pulse_we[g]),
      .i_wdata        (writedata[CNT_W-1:0]),
      .i_count        (r_count),
      .i_out_en       (w_run & r_ch_en[g]),
      .i_fault_en     (r_ch_en[g]),
      .i_response     (pwm_response[g]),
      .i_fault_clr    (w_stat_clr[g]),
      .o_pwm          (w_pwm[g]),
      .o_fault        (w_fault[g]),
      .o_pulse_shadow (w_pulse_shadow[g])
    );
  end

  assign pwm_out  = w_pwm;
  assign readdata = r_readdata;
endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi: register access, pulse widths,
// double-buffering on the wrap edge, W1C faults and async reset.
module tb_servo_pwm_multi;
  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, read, write;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  pwm_response;
  logic [3:0]  pwm_out;

  int n_cmp = 0;
  int n_mis = 0;

  servo_pwm_multi #(.NUM_CH(4), .CNT_W(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .read         (read),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .pwm_response (pwm_response),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  // Returns just after the edge where pwm_out[0] goes 0 -> 1.
  task automatic sync_rise(output int cyc);
    logic prev;
    logic rose;
    cyc  = 0;
    rose = 1'b0;
    while (!rose && cyc < 64) begin
      prev = pwm_out[0];
      @(posedge clk); #1;
      cyc++;
      rose = !prev && pwm_out[0];
    end
    chk("sync_found", {31'b0, rose}, 32'h1);
  endtask

  task automatic measure_width(output int w);
    w = 0;
    while (pwm_out[0] && w < 64) begin
      w++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_pattern(input string tag);
    logic [9:0] pat;
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      pat = {pat[8:0], pwm_out[0]};
    end
    chk(tag, 32'(pat), 32'h380);
  endtask

  initial begin
    logic [31:0] rd;
    int cyc, w, ones0, ones1, ones2, ones3;

    reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; pwm_response = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_pwm", 32'(pwm_out), 32'h0);
    @(negedge clk); reset = 1'b0;

    bus_read(4'h0, rd);  chk("rst_ctrl", rd, 32'h0);
    bus_read(4'h1, rd);  chk("rst_period", rd, 32'd20000);
    bus_read(4'h2, rd);  chk("rst_status", rd, 32'h0);
    bus_read(4'h8, rd);  chk("rst_pulse0", rd, 32'h0);

    // Basic 3-of-10 waveform; counter starts at 0 after enable
    bus_write(4'h1, 32'd10);
    bus_write(4'h8, 32'd3);
    bus_read(4'h8, rd);  chk("pulse0_rb", rd, 32'd3);
    bus_write(4'h0, 32'h8000_0001);
    check_pattern("start_pattern");
    ones0 = 0; ones1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      ones0 += int'(pwm_out[0]);
      ones1 += int'(pwm_out[1]) + int'(pwm_out[2]) + int'(pwm_out[3]);
    end
    chk("ch0_duty_20", 32'(ones0), 32'd6);
    chk("other_ch_zero", 32'(ones1), 32'd0);
    sync_rise(cyc);
    sync_rise(cyc);
    chk("period_len", 32'(cyc), 32'd10);

    // Mid-period write keeps current width; wrap-edge write is delayed a period
    bus_write(4'h8, 32'd7);
    measure_width(w);
    chk("mid_cur_width", 32'(w + 1), 32'd3);
    sync_rise(cyc);
    w = int'(pwm_out[0]);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      w += int'(pwm_out[0]);
    end
    bus_write(4'h8, 32'd2);
    chk("next_width", 32'(w), 32'd7);
    sync_rise(cyc);
    measure_width(w);
    chk("wrapwr_delayed", 32'(w), 32'd7);
    sync_rise(cyc);
    measure_width(w);
    chk("wrapwr_applied", 32'(w), 32'd2);

    // Pulse 0 -> constant low, pulse >= period -> constant high
    bus_write(4'h9, 32'd0);
    bus_write(4'hA, 32'd15);
    bus_write(4'h0, 32'h8000_0007);
    repeat (25) @(posedge clk);
    #1;
    ones1 = 0; ones2 = 0; ones3 = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      ones1 += int'(pwm_out[1]);
      ones2 += int'(pwm_out[2]);
      ones3 += int'(pwm_out[3]);
    end
    chk("ch1_const_low", 32'(ones1), 32'd0);
    chk("ch2_const_high", 32'(ones2), 32'd20);
    chk("ch3_disabled", 32'(ones3), 32'd0);

    // Faults: only ch0 has output high while response is low
    pwm_response = 4'b1100;
    repeat (20) @(posedge clk);
    #1;
    pwm_response = 4'hF;
    bus_read(4'h2, rd);
    chk("status_fault", rd & 32'h0001_000F, 32'h0001_0001);
    bus_write(4'h2, 32'h1);
    bus_read(4'h2, rd);
    chk("status_w1c", {31'b0, rd[0]}, 32'h0);
    sync_rise(cyc);
    pwm_response = 4'b1110;
    bus_write(4'h2, 32'h1);
    pwm_response = 4'hF;
    bus_read(4'h2, rd);
    chk("set_wins", {31'b0, rd[0]}, 32'h1);
    bus_write(4'h2, 32'h1);
    bus_read(4'h2, rd);
    chk("w1c_again", {31'b0, rd[0]}, 32'h0);

    // Unmapped address
    bus_write(4'h5, 32'hFFFF_FFFF);
    bus_read(4'h5, rd);  chk("unmapped_rd", rd, 32'h0);
    bus_read(4'h0, rd);  chk("ctrl_kept", rd, 32'h8000_0007);
    bus_read(4'h1, rd);  chk("period_kept", rd, 32'd10);
    repeat (3) @(posedge clk);
    #1;
    chk("readdata_hold", readdata, 32'd10);

    // Asynchronous reset mid-pulse
    sync_rise(cyc);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_pwm", 32'(pwm_out), 32'h0);
    @(negedge clk); reset = 1'b0;
    bus_read(4'h1, rd);  chk("post_rst_period", rd, 32'd20000);
    bus_read(4'h0, rd);  chk("post_rst_ctrl", rd, 32'h0);
    bus_write(4'h1, 32'd10);
    bus_write(4'h8, 32'd3);
    bus_write(4'h0, 32'h8000_0001);
    check_pattern("restart_pattern");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/servo_pwm_multi.md
SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

Interface
REQ-001 Parameter NUM_CH, default 4, number of PWM channels; legal range 1..8.
REQ-002 Parameter CNT_W, default 20, width of the period counter, period and pulse registers.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 chipselect  input  1  Avalon-MM slave select.
REQ-006 read  input  1  read strobe, qualified by chipselect.
REQ-007 write  input  1  write strobe, qualified by chipselect.
REQ-008 address  input  4  word address.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data.
REQ-011 pwm_response  input  NUM_CH  per-channel servo feedback, active-high "OK".
REQ-012 pwm_out  output  NUM_CH  registered PWM outputs.

Function
REQ-013 Register map: 0x0 CTRL (bits NUM_CH-1:0 channel enable; bit 31 global enable); 0x1 PERIOD; 0x2 STATUS; 0x8+i PULSE[i]; all other addresses read 0 and ignore writes.
REQ-014 A write takes effect on the edge where chipselect&write is high; no wait states.
REQ-015 A read returns data on readdata one cycle after chipselect&read; readdata holds its value otherwise.
REQ-016 PERIOD and PULSE[i] writes load shadow registers; reads return the shadow value; unused upper bits read 0.
REQ-017 The free-running counter counts 0..PERIOD_active-1, then wraps to 0.
REQ-018 On the wrap edge, or on any edge while global enable is 0, the active PERIOD and PULSE copies load from the shadows.
REQ-019 A shadow write on the wrap edge is not seen by that transfer; it takes effect at the next wrap.
REQ-020 While global enable is 0, the counter is held at 0 and all pwm_out are 0.
REQ-021 pwm_out[i] equals global enable AND enable[i] AND (count < PULSE_active[i]), registered, with one cycle latency from count.
REQ-022 PULSE_active[i]=0 gives constant low; PULSE_active[i] >= PERIOD_active gives constant high.
REQ-023 PERIOD_active=0 holds the counter at 0 and forces all pwm_out to 0.
REQ-024 STATUS bits NUM_CH-1:0 are sticky fault flags, set when channel i is enabled and pwm_response[i] is sampled 0 while pwm_out[i] is 1.
REQ-025 STATUS bit 16 is a sticky flag, set on every counter wrap.
REQ-026 Writing 1 to a STATUS bit clears it (W1C); when set and clear hit the same edge, set wins.
REQ-027 CTRL changes apply on the next edge and are not double-buffered.

Reset
REQ-028 Reset clears CTRL, STATUS, counter, readdata and pwm_out to 0.
REQ-029 Reset loads shadow and active PERIOD with 20000 (saturated to 2^CNT_W-1) and all PULSE with 0.
REQ-030 Reset asserted mid-period forces pwm_out low immediately (asynchronously); after release, the counter restarts at 0.

Structure
REQ-031 Package servo_pkg holds register address constants, the STATUS bit positions, and the default PERIOD.
REQ-032 Sub-module servo_pwm_channel (one instance per channel) holds the pulse shadow/active registers, the comparator, the output flop and the fault flag.

Verification
REQ-033 PERIOD=10, PULSE[0]=3, CTRL=0x80000001 -> pwm_out[0] high 3 of every 10 cycles; other channels stay 0.
REQ-034 Mid-period write PULSE[0]=7 -> current period keeps width 3; next period is width 7; a write on the wrap edge is delayed by one further period.
REQ-035 PULSE[1]=0 and PULSE[2]=15 with PERIOD=10, all enabled -> ch1 constant 0, ch2 constant 1.
REQ-036 pwm_response[0]=0 while pwm_out[0]=1 -> STATUS bit0=1 on the following read; write STATUS=0x1 -> bit0=0 unless the fault recurs in the same cycle.
REQ-037 Reset pulsed mid-period -> pwm_out=0 at once; a PERIOD read returns 20000; the counter restarts at 0 after release.
REQ-038 Read of address 0x5 -> readdata=0 one cycle later; write to 0x5 -> no register changes.
